// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the shift-add multiplier controller.
//   MUL_WIDTH  default operand width
//   mul_cnt_w  width of an iteration counter that can hold the value w
//   MUL_CNT_W  counter width for the default operand width
//   state_t    controller state encoding
`timescale 1ns/1ps
package mul_pkg;

    localparam int MUL_WIDTH = 8;

    function automatic int mul_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int MUL_CNT_W = mul_cnt_w(MUL_WIDTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/result bundle of the multiplier controller.
//   req_valid / req_ready   operand handshake (requester -> controller)
//   data1, data2            multiplicand, multiplier
//   signed_mode             1: two's-complement operands, 0: unsigned
//   res_valid / res_ready   result handshake (controller -> consumer)
//   result                  low WIDTH bits of product
//   product                 full 2*WIDTH product
//   busy                    controller holds an operation
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer keeps valid and its data
// steady until that edge; ready may be asserted independently of valid.
// master: requester/consumer side.  slave: the controller.
`timescale 1ns/1ps
interface mul_sequencer_if
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic [WIDTH-1:0]     data1;
    logic [WIDTH-1:0]     data2;
    logic                 signed_mode;
    logic                 res_valid;
    logic                 res_ready;
    logic [WIDTH-1:0]     result;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output req_valid, data1, data2, signed_mode, res_ready,
        input  req_ready, res_valid, result, product, busy
    );

    modport slave (
        input  req_valid, data1, data2, signed_mode, res_ready,
        output req_ready, res_valid, result, product, busy
    );

endinterface

// File: rtl/mul_step.sv
// mul_step: one combinational add-and-shift step of the multiplier.
//   acc          upper half of the running product
//   mcand        multiplicand magnitude
//   mplier       lower half: remaining multiplier bits, product bits shifted in on top
//   acc_next     upper half after the step
//   mplier_next  lower half after the step
`timescale 1ns/1ps
module mul_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mplier_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    always_comb begin
        addend      = mplier[0] ? mcand : '0;
        // WIDTH+1 bits keep the carry so the shift below brings it into acc.
        sum         = {1'b0, acc} + {1'b0, addend};
        acc_next    = sum[WIDTH:1];
        mplier_next = {sum[0], mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier controller (ALU MUL).
// Takes one operand pair, runs WIDTH add-and-shift steps through a single
// mul_step, fixes the sign and holds the product until the consumer takes it.
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   bus        mul_sequencer_if.slave (operand and result handshakes)
//   dbg_state  current controller state
// Optional build macro MUL_EARLY_TERM_EN: leave ITER as soon as the remaining
// multiplier bits are all zero (at least one step is always taken).
// Flow: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
`timescale 1ns/1ps
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus,
    output state_t          dbg_state
);

    localparam int CNT_W = mul_cnt_w(WIDTH);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     d1_q, d2_q;
    logic                 smode_q;
    logic                 sign_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     acc_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [WIDTH-1:0]     acc_next, mplier_next;
    logic [2*WIDTH-1:0]   mag;
    logic                 iter_exit;
`ifdef MUL_EARLY_TERM_EN
    // Unconsumed multiplier bits; zero means the remaining steps only shift.
    logic [WIDTH-1:0]     rem_q;
`endif

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc_q),
        .mcand       (mcand_q),
        .mplier      (mplier_q),
        .acc_next    (acc_next),
        .mplier_next (mplier_next)
    );

    // ITER leaves on the cycle after the counter has reached zero, so the
    // step count is WIDTH and ITER occupies WIDTH+1 cycles.
    always_comb begin
        iter_exit = (cnt_q == '0);
`ifdef MUL_EARLY_TERM_EN
        if (rem_q == '0 && cnt_q != CNT_W'(WIDTH))
            iter_exit = 1'b1;
`endif
    end

    // After an early exit the product sits cnt_q bits too high in {acc, mplier};
    // the bits below it are the all-zero unconsumed multiplier bits.
    always_comb begin
`ifdef MUL_EARLY_TERM_EN
        mag = {acc_q, mplier_q} >> cnt_q;
`else
        mag = {acc_q, mplier_q};
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = PREP;
            PREP:    state_d = ITER;
            ITER:    if (iter_exit) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            smode_q   <= 1'b0;
            sign_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
`ifdef MUL_EARLY_TERM_EN
            rem_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        d1_q    <= bus.data1;
                        d2_q    <= bus.data2;
                        smode_q <= bus.signed_mode;
                    end
                end
                PREP: begin
                    sign_q   <= smode_q & (d1_q[WIDTH-1] ^ d2_q[WIDTH-1]);
                    // Negating the most negative value wraps to itself, which
                    // read as unsigned is exactly its magnitude.
                    mcand_q  <= (smode_q && d1_q[WIDTH-1]) ? (~d1_q + 1'b1) : d1_q;
                    mplier_q <= (smode_q && d2_q[WIDTH-1]) ? (~d2_q + 1'b1) : d2_q;
                    acc_q    <= '0;
                    cnt_q    <= CNT_W'(WIDTH);
`ifdef MUL_EARLY_TERM_EN
                    rem_q    <= (smode_q && d2_q[WIDTH-1]) ? (~d2_q + 1'b1) : d2_q;
`endif
                end
                ITER: begin
                    if (!iter_exit) begin
                        acc_q    <= acc_next;
                        mplier_q <= mplier_next;
                        cnt_q    <= cnt_q - CNT_W'(1);
`ifdef MUL_EARLY_TERM_EN
                        rem_q    <= rem_q >> 1;
`endif
                    end
                end
                FIX: begin
                    // Two's-complement negation of 0 is 0, so no -0 case arises.
                    product_q <= sign_q ? (~mag + 1'b1) : mag;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.product   = product_q;
    assign bus.result    = product_q[WIDTH-1:0];
    assign dbg_state     = state_q;

endmodule
